uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 16x-oversampling UART receiver: 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
- Pairs with the team's UART transmitter and shares its baud divisor, parity and stop-bit settings from the same CSR block.
- Deserialises rx_i into bytes and presents each byte with per-byte error flags on a single-entry valid/ready output.

Parameters:
OVERSAMPLE, 8'd16, ticks per bit period; even, >= 4

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
baud_div  input  16  tick divider; one tick every baud_div+1 clk
rx_i  input  1  asynchronous serial line, idle high
parity  input  2  0=None, 1=Even, 2=Odd, 3=treated as None
stop2  input  1  1 = two stop bits checked
data_o  output  8  received byte
valid_o  output  1  data_o and error flags valid
ready_i  input  1  consumer accepts byte when valid_o&&ready_i
parity_err_o  output  1  byte in data_o had a parity mismatch
frame_err_o  output  1  byte in data_o had a stop bit sampled low
overrun_o  output  1  one-clk pulse: completed byte dropped, holding register full

Behaviour:
- Reset values: data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0; FSM=IDLE; divider=0; both synchroniser flops=1.
- rst mid-frame aborts the frame and drops any held byte.
- Synchroniser: rx_i passes through 2 flops to give rx_s. All sampling uses rx_s.
- Tick generator: on div==0, reload baud_div and pulse tick for one clk; otherwise decrement. baud_div=0 gives a tick every clk. FSM advances only on tick.
- IDLE: on a tick with rx_s==0, set os=OVERSAMPLE/2-1 and go to START.
- START: os decrements per tick. At os==0, sample mid-bit:
  - rx_s==0: go to DATA, os=OVERSAMPLE-1, bitn=0.
  - rx_s==1: false start; return to IDLE with no output.
- DATA: at os==0, sample into shift register MSB (sh<={rx_s,sh[7:1]}), reload os, bitn++. After bitn==7: go to PAR if parity is 1 or 2, else go to STOP.
- PAR: at os==0, sample p.
  - Even: error if p != ^sh.
  - Odd: error if p != ~^sh.
  - Go to STOP with os reloaded.
- STOP: at os==0, sample. A low sample sets the frame error.
  - If stop2 and this is the first stop bit: reload os and sample a second stop bit the same way.
  - Then complete the byte.
- Completion, on the clk of the final stop-bit sample tick:
  - valid_o clear, or valid_o&&ready_i in the same clk: load data_o and both error flags, set valid_o=1 on the next clk.
  - valid_o set and ready_i low: drop the new byte, keep the held byte and its flags, pulse overrun_o for 1 clk.
- After completion:
  - No frame error: go to IDLE. A start bit may be detected on the next tick.
  - Frame error: go to WAITHI and stay until a tick with rx_s==1, then go to IDLE. A break is reported once, not repeatedly.
- Handshake: valid_o stays high until a clk with ready_i=1. That clk clears valid_o unless a new byte loads in the same clk. data_o and flags are stable while valid_o=1.
- Latency: valid_o rises 1 clk after the tick on which the last stop bit is sampled. Mid-stop sampling means this is ~OVERSAMPLE/2 ticks before the nominal end of the stop bit.
- parity, stop2 and baud_div changes take effect at the next frame. Changing them mid-frame gives undefined data but must not hang the FSM.

Test Plan:
- Basic byte: baud_div=0, parity=0, stop2=0; drive 0xA5 frame at 16 clk/bit -> valid_o=1 with data_o=0xA5, both error flags 0; ready_i=1 clears valid_o the next clk.
- Parity: parity=1, send 0x03 with parity bit 0 -> parity_err_o=0. Same byte with parity bit 1 -> parity_err_o=1. parity=2, 0x03 with parity bit 1 -> parity_err_o=0.
- Framing and break: stop bit driven 0 -> frame_err_o=1, data_o=received byte. Hold rx_i low for 40 bit times -> exactly one valid_o; next frame after rx_i returns high decodes correctly (0x5A).
- False start: rx_i low for 4 ticks then high -> no valid_o, FSM back in IDLE. Following 0x3C frame decodes correctly.
- Overrun and back-to-back: ready_i=0; send 0x11 then 0x22 -> data_o stays 0x11, overrun_o pulses once. Then ready_i=1 held; send 0x33 and 0x44 back-to-back with stop2=1 -> both delivered in order, no overrun.
- Reset mid-frame: assert rst after 3 data bits of 0xFF -> all outputs 0. Subsequent 0x81 frame (baud_div=3) -> data_o=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 8N/E/O with 1 or 2 stop bits, byte plus
// error flags presented on a single-entry valid/ready holding register.
module uart_rx #(
  parameter logic [7:0] OVERSAMPLE = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        rx_i,
  input  logic [1:0]  parity,
  input  logic        stop2,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAITHI} state_e;

  localparam logic [7:0] HalfM1 = OVERSAMPLE / 8'd2 - 8'd1;
  localparam logic [7:0] FullM1 = OVERSAMPLE - 8'd1;

  state_e      state_q, state_d;
  logic        rxSync1_q, rxSync2_q;
  logic [15:0] div_q, div_d;
  logic        tick;
  logic [7:0]  os_q, os_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  sh_q, sh_d;
  logic        parErr_q, parErr_d;
  logic        frmErr_q, frmErr_d;
  logic        secondStop_q, secondStop_d;
  logic [1:0]  parMode_q, parMode_d;
  logic        twoStop_q, twoStop_d;
  logic        complete;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        parErrOut_q, parErrOut_d;
  logic        frmErrOut_q, frmErrOut_d;
  logic        overrun_q, overrun_d;

  assign tick = (div_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rxSync1_q    <= 1'b1;
      rxSync2_q    <= 1'b1;
      div_q        <= 16'd0;
      os_q         <= 8'd0;
      bitn_q       <= 3'd0;
      sh_q         <= 8'd0;
      parErr_q     <= 1'b0;
      frmErr_q     <= 1'b0;
      secondStop_q <= 1'b0;
      parMode_q    <= 2'd0;
      twoStop_q    <= 1'b0;
      data_q       <= 8'd0;
      valid_q      <= 1'b0;
      parErrOut_q  <= 1'b0;
      frmErrOut_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rxSync1_q    <= rx_i;
      rxSync2_q    <= rxSync1_q;
      div_q        <= div_d;
      os_q         <= os_d;
      bitn_q       <= bitn_d;
      sh_q         <= sh_d;
      parErr_q     <= parErr_d;
      frmErr_q     <= frmErr_d;
      secondStop_q <= secondStop_d;
      parMode_q    <= parMode_d;
      twoStop_q    <= twoStop_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parErrOut_q  <= parErrOut_d;
      frmErrOut_q  <= frmErrOut_d;
      overrun_q    <= overrun_d;
    end
  end

  // Framing settings are captured at start detection so mid-frame CSR writes cannot stall the FSM.
  always_comb begin
    state_d      = state_q;
    div_d        = tick ? baud_div : div_q - 16'd1;
    os_d         = os_q;
    bitn_d       = bitn_q;
    sh_d         = sh_q;
    parErr_d     = parErr_q;
    frmErr_d     = frmErr_q;
    secondStop_d = secondStop_q;
    parMode_d    = parMode_q;
    twoStop_d    = twoStop_q;
    complete     = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxSync2_q) begin
            os_d      = HalfM1;
            parMode_d = parity;
            twoStop_d = stop2;
            state_d   = START;
          end
        end
        START: begin
          if (os_q != 8'd0) begin
            os_d = os_q - 8'd1;
          end else if (!rxSync2_q) begin
            os_d         = FullM1;
            bitn_d       = 3'd0;
            parErr_d     = 1'b0;
            frmErr_d     = 1'b0;
            secondStop_d = 1'b0;
            state_d      = DATA;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          if (os_q != 8'd0) begin
            os_d = os_q - 8'd1;
          end else begin
            sh_d   = {rxSync2_q, sh_q[7:1]};
            os_d   = FullM1;
            bitn_d = bitn_q + 3'd1;
            if (bitn_q == 3'd7)
              state_d = (parMode_q == 2'd1 || parMode_q == 2'd2) ? PAR : STOP;
          end
        end
        PAR: begin
          if (os_q != 8'd0) begin
            os_d = os_q - 8'd1;
          end else begin
            if (parMode_q == 2'd2) parErr_d = (rxSync2_q != ~^sh_q);
            else                   parErr_d = (rxSync2_q != ^sh_q);
            os_d    = FullM1;
            state_d = STOP;
          end
        end
        STOP: begin
          if (os_q != 8'd0) begin
            os_d = os_q - 8'd1;
          end else begin
            frmErr_d = frmErr_q | ~rxSync2_q;
            if (twoStop_q && !secondStop_q) begin
              secondStop_d = 1'b1;
              os_d         = FullM1;
            end else begin
              complete = 1'b1;
              state_d  = frmErr_d ? WAITHI : IDLE;
            end
          end
        end
        WAITHI: begin
          if (rxSync2_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completed byte loads only if the holding register is empty or being drained this clk.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    parErrOut_d = parErrOut_q;
    frmErrOut_d = frmErrOut_q;
    overrun_d   = 1'b0;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (complete) begin
      if (!valid_q || ready_i) begin
        data_d      = sh_q;
        parErrOut_d = parErr_q;
        frmErrOut_d = frmErr_d;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = parErrOut_q;
  assign frame_err_o  = frmErrOut_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are built from the byte, parity
// and stop settings; a monitor checks every accepted byte against a queue.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_i;
  logic [1:0]  parity;
  logic        stop2;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;
  int ovCount = 0;
  int expOv = 0;
  logic [9:0] expQ[$];

  uart_rx dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx_i(rx_i), .parity(parity),
    .stop2(stop2), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, want);
    end
  endtask

  // Monitor: every handshake consumes one expected {data, parity_err, frame_err}.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun_o) ovCount++;
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedByte", {22'd0, data_o, parity_err_o, frame_err_o}, 32'h3ff);
        end else begin
          checkOutput("rxByte", {22'd0, data_o, parity_err_o, frame_err_o},
                      {22'd0, expQ.pop_front()});
        end
      end
    end
  end

  task automatic driveBit(input logic b);
    rx_i = b;
    repeat (16 * (int'(baud_div) + 1)) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] par, input logic st2,
                               input logic badPar, input logic badStop, input logic dropped,
                               input int gapBits);
    logic pe, pb;
    parity = par;
    stop2  = st2;
    pe = (par == 2'd1) || (par == 2'd2);
    pb = (par == 2'd2) ? ~^d : ^d;
    if (badPar) pb = ~pb;
    if (dropped) expOv++;
    else expQ.push_back({d, pe && badPar, badStop});
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    if (pe) driveBit(pb);
    driveBit(~badStop);
    if (st2) driveBit(1'b1);
    for (int i = 0; i < gapBits; i++) driveBit(1'b1);
  endtask

  task automatic waitValid(input int budget);
    for (int i = 0; i < budget && !valid_o; i++) @(negedge clk);
    if (!valid_o) checkOutput("validTimeout", {31'd0, valid_o}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rx_i = 1'b1; ready_i = 1'b0; baud_div = 16'd0; parity = 2'd0; stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetData", {24'd0, data_o}, 32'd0);
    checkOutput("resetValid", {31'd0, valid_o}, 32'd0);
    checkOutput("resetParErr", {31'd0, parity_err_o}, 32'd0);
    checkOutput("resetFrmErr", {31'd0, frame_err_o}, 32'd0);
    checkOutput("resetOverrun", {31'd0, overrun_o}, 32'd0);
    rst = 1'b0;
    driveBit(1'b1);

    // Basic byte, then handshake clears valid
    applyStimulus(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    waitValid(500);
    checkOutput("basicHeld", {24'd0, data_o}, 32'hA5);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("validCleared", {31'd0, valid_o}, 32'd0);

    // Parity cases
    applyStimulus(8'h03, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(8'h03, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    applyStimulus(8'h03, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(8'h03, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // Framing error, then a 40-bit break reported once
    applyStimulus(8'hC7, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    parity = 2'd0; stop2 = 1'b0;
    expQ.push_back({8'h00, 1'b0, 1'b1});
    for (int i = 0; i < 40; i++) driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    applyStimulus(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // False start
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("falseStartNoValid", {31'd0, valid_o}, 32'd0);
    applyStimulus(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // Overrun with ready low, then back-to-back two-stop frames
    ready_i = 1'b0;
    applyStimulus(8'h11, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    checkOutput("overrunHeldData", {24'd0, data_o}, 32'h11);
    checkOutput("overrunHeldValid", {31'd0, valid_o}, 32'd1);
    checkOutput("overrunPulses", ovCount, expOv);
    ready_i = 1'b1;
    applyStimulus(8'h33, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(8'h44, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("backToBackOverrun", ovCount, expOv);

    // Reset mid-frame drops both the frame and a held byte
    baud_div = 16'd3;
    stop2 = 1'b0;
    ready_i = 1'b0;
    driveBit(1'b1);
    applyStimulus(8'h77, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expQ.delete();
    checkOutput("midResetData", {24'd0, data_o}, 32'd0);
    checkOutput("midResetValid", {31'd0, valid_o}, 32'd0);
    checkOutput("midResetFlags", {30'd0, parity_err_o, frame_err_o}, 32'd0);
    rst = 1'b0;
    ready_i = 1'b1;
    driveBit(1'b1);
    driveBit(1'b1);
    applyStimulus(8'h81, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // Randomised frames
    for (int n = 0; n < 20; n++) begin
      baud_div = 16'($urandom_range(0, 2));
      driveBit(1'b1);
      applyStimulus(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), 1'b0, 2);
    end

    repeat (200) @(posedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 32'd0);
    checkOutput("overrunTotal", ovCount, expOv);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
